// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked WIDTH-bit ALU with registered result and N/Z/C/V flags.
// Optional multi-cycle shift-add multiplier is enabled by defining ALU_MUL_EN.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           flags,
    output logic                 busy
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [3:0]           flags_q, flags_d;

    logic [WIDTH:0]       add_w, sub_w;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c, alu_v;
    logic [3:0]           alu_flags;
    logic                 accept, out_xfer, load_alu;

    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // Single-cycle datapath; MUL falls to the default arm and yields zero.
    always_comb begin
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_SHL: begin
                alu_r = {a[WIDTH-2:0], 1'b0};
                alu_c = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_r = {1'b0, a[WIDTH-1:1]};
                alu_c = a[0];
            end
            default: alu_r = '0;
        endcase
        alu_flags = {alu_r[WIDTH-1], (alu_r == '0), alu_c, alu_v};
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       sum_w;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 mul_done;

    // Multiplier lives in the low half of the accumulator and shifts out as the product shifts in.
    assign sum_w    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {sum_w, acc_q[WIDTH-1:1]};

    assign in_ready = (state_q != S_MUL) && (!out_valid_q || out_ready);
    assign busy     = (state_q == S_MUL);
    assign load_alu = accept && (op != OP_MUL);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mul_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && (op == OP_MUL)) begin
                    state_d = S_MUL;
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    cnt_d   = CW'(WIDTH);
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d  = S_IDLE;
                    mul_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign busy     = 1'b0;
    assign load_alu = accept;
`endif

    // A load only happens when the slot is empty or draining on this same edge.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (out_xfer) begin
            out_valid_d = 1'b0;
        end
        if (load_alu) begin
            out_valid_d = 1'b1;
            result_d    = {{WIDTH{1'b0}}, alu_r};
            flags_d     = alu_flags;
        end
`ifdef ALU_MUL_EN
        if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = acc_step;
            flags_d     = {acc_step[2*WIDTH-1], (acc_step == '0),
                           (acc_step[2*WIDTH-1:WIDTH] != '0), 1'b0};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=4, covering both ALU_MUL_EN builds.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic       busy;

    logic [11:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one op and wait (bounded) for acceptance; expectation is queued at the accepting cycle.
    task automatic send(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb,
                        input logic [7:0] er, input logic [3:0] ef, input bit push);
        int n;
        op = o; a = va; b = vb; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else if (push) begin
            exp_q.push_back({er, ef});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: every output transfer pops and compares one expectation.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h/%0h expected none", result, flags);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 32'(result), 32'(e[11:4]));
                    check("sb_flags", 32'(flags), 32'(e[3:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Back-to-back single-cycle ops
        send(3'b000, 4'd7, 4'd9, 8'h00, 4'b0110, 1'b1);
        send(3'b000, 4'd7, 4'd1, 8'h08, 4'b1001, 1'b1);
        send(3'b001, 4'd3, 4'd5, 8'h0E, 4'b1010, 1'b1);
        send(3'b001, 4'd5, 4'd5, 8'h00, 4'b0100, 1'b1);
        send(3'b001, 4'd8, 4'd1, 8'h07, 4'b0001, 1'b1);
        send(3'b010, 4'hC, 4'hA, 8'h08, 4'b1000, 1'b1);
        send(3'b011, 4'h3, 4'h4, 8'h07, 4'b0000, 1'b1);
        send(3'b101, 4'h9, 4'h0, 8'h02, 4'b0010, 1'b1);
        send(3'b110, 4'h9, 4'h0, 8'h04, 4'b0010, 1'b1);
        @(negedge clk);
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_result", 32'(result), 32'h04);
        @(posedge clk); #1;

`ifdef ALU_MUL_EN
        send(3'b111, 4'd15, 4'd15, 8'hE1, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mul_busy", 32'(busy), 32'd1);
            check("mul_in_ready", 32'(in_ready), 32'd0);
            check("mul_out_valid_low", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("mul_done_valid", 32'(out_valid), 32'd1);
        check("mul_done_busy", 32'(busy), 32'd0);
`else
        send(3'b111, 4'd5, 4'd5, 8'h00, 4'b0100, 1'b1);
        @(negedge clk);
        check("mul_off_valid", 32'(out_valid), 32'd1);
        check("mul_off_busy", 32'(busy), 32'd0);
        check("mul_off_in_ready", 32'(in_ready), 32'd1);
`endif
        repeat (2) @(posedge clk);
        #1;

        // Backpressure then same-edge handoff
        out_ready = 1'b0;
        send(3'b100, 4'hA, 4'h5, 8'h0F, 4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(result), 32'h0F);
            check("bp_flags", 32'(flags), 32'b1000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'b010, 4'hC, 4'hA, 8'h08, 4'b1000, 1'b1);
        @(negedge clk);
        check("handoff_out_valid", 32'(out_valid), 32'd1);
        check("handoff_result", 32'(result), 32'h08);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the same cycle as in_valid drops the op
        op = 3'b000; a = 4'd1; b = 4'd1; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_drop_valid", 32'(out_valid), 32'd0);
        check("rst_drop_result", 32'(result), 32'd0);

`ifdef ALU_MUL_EN
        // Reset during MUL step 2 aborts
        @(posedge clk); #1;
        send(3'b111, 4'd3, 4'd3, 8'h09, 4'b0000, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
`endif

        repeat (10) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit ALU. Operand width is set by a parameter, and both input and output use valid/ready handshakes. Results and a N/Z/C/V flag set are registered. An optional multi-cycle shift-add unsigned multiplier is included. The block sits between the top-level pin wrapper (operands and opcode from dedicated/bidirectional inputs) and the output pins or a downstream consumer that may stall.

## Interface
- WIDTH, 4: operand width in bits; legal values 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  opcode.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  2*WIDTH  result, zero-extended except for MUL.
- flags  output  4  {N, Z, C, V}.
- busy  output  1  multiply in progress.

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a<<1.
  - 110 SHR: a>>1, logical.
  - 111 MUL: unsigned a*b.
- Transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- in_ready = (state != MUL) && (!out_valid || out_ready). Back-to-back single-cycle operations sustain one per clock.
- States:
  - IDLE → MUL when a 111 op is accepted.
  - MUL → IDLE after WIDTH steps.
  - Non-MUL ops never leave IDLE.
- MUL datapath:
  - Latch a and b, clear the accumulator, counter = WIDTH.
  - Each MUL cycle: if multiplier LSB is 1, add the multiplicand into the upper accumulator half; then shift right one bit; decrement the counter.
  - On the final step, load result/flags and set out_valid.
- result[2W-1:W] = 0 for all non-MUL ops.
- Flags (W = WIDTH, R = result):
  - Z: R[W-1:0]==0 for non-MUL ops; R==0 for MUL.
  - N: R[W-1] for non-MUL ops; R[2W-1] for MUL.
  - C:
    - ADD: carry out.
    - SUB: borrow, i.e. 1 when a<b unsigned.
    - SHL: a[W-1].
    - SHR: a[0].
    - Logic ops: 0.
    - MUL: R[2W-1:W] != 0.
  - V:
    - ADD: signed overflow, a[W-1]==b[W-1] && R[W-1]!=a[W-1].
    - SUB: a[W-1]!=b[W-1] && R[W-1]!=a[W-1].
    - All other ops: 0.
- Output register holds result/flags stable while out_valid && !out_ready. A new load overwrites only on the same edge the old value transfers, or when out_valid is 0.
- busy = (state == MUL).

## Timing
- Reset values:
  - out_valid = 0.
  - result = 0.
  - flags = 0.
  - busy = 0.
  - state = IDLE.
  - in_ready = 1 in the first cycle after reset deasserts.
- Non-MUL latency: accepted at edge e0; out_valid high after e0, i.e. 1 cycle.
- MUL latency: accepted at e0; steps on e1..eWIDTH; out_valid high after eWIDTH, i.e. WIDTH+1 cycles. in_ready is 0 for the whole MUL period.
- MUL completion is not gated by out_ready. MUL cannot start while a result is held, because in_ready is 0.
- Simultaneous output transfer and new accept: the old result leaves and the new one loads on the same edge, so out_valid stays 1.
- Reset mid-MUL aborts the operation: out_valid = 0, busy = 0, and no result is produced.
- A rst asserted in the same cycle as in_valid takes priority; the operation is dropped.

## Configuration
- ALU_MUL_EN defined: MUL state, counter and accumulator are present, behaving as above.
- ALU_MUL_EN undefined:
  - Op 111 completes in 1 cycle with result = 0 and flags = 4'b0100 (Z only).
  - busy is tied 0.
  - in_ready = !out_valid || out_ready.

## Test plan
- WIDTH=4, ADD a=7, b=9, out_ready=1 → 1 cycle later result=0x00, flags N0 Z1 C1 V0.
- WIDTH=4, ADD a=7, b=1 → result=0x08, flags N1 Z0 C0 V1. Then SUB a=3, b=5 → result=0x0E, flags N1 Z0 C1 V0.
- WIDTH=4, ALU_MUL_EN, MUL a=15, b=15 → busy for 4 cycles, in_ready=0; out_valid on the 5th cycle after acceptance; result=0xE1, flags N1 Z0 C1 V0.
- Backpressure: XOR a=0xA, b=0x5 with out_ready=0 for 3 cycles → result=0x0F held stable, out_valid=1, in_ready=0. Raise out_ready together with a new AND 0xC&0xA → same-edge handoff, next result=0x08, out_valid never drops.
- Reset mid-MUL: assert rst at step 2 of MUL 3*3 → next cycle out_valid=0, busy=0, in_ready=1; no result emitted.
- ALU_MUL_EN undefined: op 111, a=5, b=5 → 1 cycle later result=0, flags=4'b0100.
